// File: rtl/nibble_link_pkg.sv
// nibble_link_pkg: state encodings and link framing shared by both ends of the nibble link
package nibble_link_pkg;
  localparam int LINK_VALID_BIT = 4;
  localparam int LINK_W = 5;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RELEASE = 3'd3,
    ABORT   = 3'd4
  } state_t;
endpackage

// File: rtl/nibble_link_fifo.sv
// nibble_link_fifo: synchronous FIFO with occupancy count and a look-ahead at the second entry
module nibble_link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         next_head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  assign next_head = mem[rd_ptr + AW'(1)];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/nibble_link_tx.sv
// nibble_link_tx: buffers bytes and sends each as two nibbles (low first) with a four-phase ack handshake
module nibble_link_tx
  import nibble_link_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [LINK_W-1:0]             link_out,
  input  logic                          link_ack_n,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic nib_sel, nib_n, pop, ack, full, empty, timed_out, more;
  logic [1:0] ack_sync;
  logic [15:0] timer;
  logic [7:0] head, next_head, byte_n;
  logic [3:0] nib;
  logic [LINK_W-1:0] link_n;
  nibble_link_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(in_valid), .push_data(in_data), .pop(pop),
    .head(head), .next_head(next_head), .full(full), .empty(empty), .level(fifo_level)
  );
  assign in_ready = ~full;
  assign busy = (state != IDLE) || !empty;
  assign ack = ~ack_sync[1];
  assign timed_out = timer == TO_LAST;
  // another byte remains after the pop; a same-cycle push is picked up via IDLE
  assign more = fifo_level[$clog2(FIFO_DEPTH):1] != '0;
  always_comb begin
    state_n = state;
    nib_n = nib_sel;
    pop = 1'b0;
    case (state)
      IDLE: begin
        nib_n = 1'b0;
        state_n = empty ? IDLE : SETUP;
      end
      SETUP: state_n = (timer == SETUP_LAST) ? STROBE : SETUP;
      STROBE: state_n = ack ? RELEASE : timed_out ? ABORT : STROBE;
      RELEASE:
        if (!ack) begin
          pop = nib_sel;
          nib_n = ~nib_sel;
          state_n = (!nib_sel || more) ? SETUP : IDLE;
        end else if (timed_out) state_n = ABORT;
      ABORT: begin
        pop = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // when popping, the nibble for the next SETUP comes from the entry behind the head
    byte_n = pop ? next_head : head;
    nib = nib_n ? byte_n[7:4] : byte_n[3:0];
    link_n = '0;
    link_n[LINK_VALID_BIT] = state_n == STROBE;
    link_n[3:0] = (state_n inside {SETUP, STROBE, RELEASE}) ? nib : 4'h0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_sync <= 2'b11;
      state <= IDLE;
      nib_sel <= 1'b0;
      timer <= '0;
      link_out <= '0;
      err_timeout <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[0], link_ack_n};
      state <= state_n;
      nib_sel <= nib_n;
      timer <= (state_n != state) ? '0 : timer + 16'd1;
      link_out <= link_n;
      err_timeout <= state_n == ABORT;
    end
endmodule
